// File: rtl/see_scheduler.sv
// SEE fault-injection campaign controller: timed, round-robin, LFSR-positioned upset masks.
// Define SEE_MULTI_BIT_EN for adjacent double-bit upsets; the default build injects single-bit upsets.
module see_scheduler #(
  parameter int          W      = 32,
  parameter int          GROUPS = 4,
  parameter int          CW     = 16,
  parameter logic [31:0] SEED   = 32'hACE1_2024
) (
  input  logic              s_clk_i,
  input  logic              s_reset_i,
  input  logic              s_start_i,
  input  logic              s_stop_i,
  input  logic [CW-1:0]     s_interval_i,
  input  logic [CW-1:0]     s_count_i,
  input  logic [GROUPS-1:0] s_group_en_i,
  output logic [W-1:0]      s_upset_o [GROUPS],
  output logic              s_busy_o,
  output logic              s_done_o,
  output logic [CW-1:0]     s_injected_o
);
  localparam int          IW   = $clog2(W);
  localparam int          PW   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, WAIT, INJECT, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       lfsr_q;
  logic [CW-1:0]     cnt_q, interval_q, count_q, injected_q;
  logic [PW-1:0]     ptr_q;
  logic [W-1:0]      mask_q [GROUPS];

  logic [2*GROUPS-1:0] en_rot;
  logic [PW-1:0]     sel;
  logic              sel_found;
  logic [IW-1:0]     idx;
  logic [W-1:0]      bit_mask;
  logic [CW-1:0]     inj_next, iv1;
  logic              go, fire;

  assign iv1      = (s_interval_i == '0) ? CW'(1) : s_interval_i;
  assign inj_next = (&injected_q) ? injected_q : injected_q + CW'(1);
  assign idx      = lfsr_q[IW-1:0];
  assign go       = s_start_i && (|s_group_en_i);

`ifdef SEE_MULTI_BIT_EN
  // idx+1 wraps inside IW bits because W is a power of two
  assign bit_mask = (W'(1) << idx) | (W'(1) << IW'(idx + IW'(1)));
`else
  assign bit_mask = W'(1) << idx;
`endif

  // Rotate the enables so bit j corresponds to group (ptr+1+j) mod GROUPS
  always_comb begin
    en_rot    = {s_group_en_i, s_group_en_i} >> (int'(ptr_q) + 1);
    sel       = '0;
    sel_found = 1'b0;
    for (int j = 0; j < GROUPS; j++) begin
      if (!sel_found && en_rot[j]) begin
        sel_found = 1'b1;
        sel       = PW'((int'(ptr_q) + 1 + j) % GROUPS);
      end
    end
  end

  assign fire = (state_q == WAIT) && !s_stop_i && (cnt_q == '0) && sel_found;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = WAIT;
      WAIT:    if (s_stop_i) state_d = IDLE;
               else if (fire) state_d = INJECT;
      INJECT:  if (s_stop_i) state_d = IDLE;
               else if (count_q != '0 && inj_next == count_q) state_d = DONE;
               else state_d = WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      interval_q <= '0;
      count_q    <= '0;
      injected_q <= '0;
      ptr_q      <= '0;
      for (int g = 0; g < GROUPS; g++) mask_q[g] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != IDLE)
        lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
      // Masks live for exactly the INJECT cycle
      for (int g = 0; g < GROUPS; g++)
        mask_q[g] <= (fire && sel == PW'(g)) ? bit_mask : '0;
      case (state_q)
        IDLE: if (go) begin
          interval_q <= iv1;
          count_q    <= s_count_i;
          injected_q <= '0;
          cnt_q      <= iv1 - CW'(1);
        end
        WAIT: if (!s_stop_i) begin
          if (cnt_q != '0)  cnt_q <= cnt_q - CW'(1);
          else if (!sel_found) cnt_q <= interval_q - CW'(1);
          else ptr_q <= sel;
        end
        INJECT: if (!s_stop_i) begin
          injected_q <= inj_next;
          cnt_q      <= interval_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb
    for (int g = 0; g < GROUPS; g++) s_upset_o[g] = mask_q[g];

  assign s_busy_o     = (state_q != IDLE);
  assign s_done_o     = (state_q == DONE);
  assign s_injected_o = injected_q;
endmodule

// File: tb/tb_see_scheduler.sv
// Randomized bench for see_scheduler against a timeline model of the campaign rules.
module tb_see_scheduler;
  localparam int          W    = 32;
  localparam int          G    = 4;
  localparam int          CW   = 16;
  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [CW-1:0] interval = '0, count = '0;
  logic [G-1:0]  group_en = '0;
  logic [W-1:0]  upset [G];
  logic          busy, done;
  logic [CW-1:0] injected;

  see_scheduler #(.W(W), .GROUPS(G), .CW(CW), .SEED(SEED)) dut (
    .s_clk_i(clk), .s_reset_i(rst), .s_start_i(start), .s_stop_i(stop),
    .s_interval_i(interval), .s_count_i(count), .s_group_en_i(group_en),
    .s_upset_o(upset), .s_busy_o(busy), .s_done_o(done), .s_injected_o(injected));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] m_lfsr = SEED;
  int          m_ptr  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lshift(logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int pick(int ptr, logic [G-1:0] en);
    for (int k = 1; k <= G; k++)
      if (en[(ptr + k) % G]) return (ptr + k) % G;
    return -1;
  endfunction

  function automatic logic [31:0] mk(logic [31:0] l);
    int i;
    logic [31:0] m;
    i = int'(l % W);
    m = 32'h1 << i;
`ifdef SEE_MULTI_BIT_EN
    m |= 32'h1 << ((i + 1) % W);
`endif
    return m;
  endfunction

  // Cycle c = c-th cycle after the start sample. Injection k lands at c=k*(I+1),
  // using the LFSR value of cycle c-1; done at c=N*(I+1)+1.
  task automatic campaign(int iv, int cnt, logic [G-1:0] en, int stop_at, int rst_at, bit noisy);
    int I, D, abort, endc, lim, inj, g;
    logic [31:0] cur, prev;
    logic [31:0] expm [G];
    I     = (iv == 0) ? 1 : iv;
    D     = cnt * (I + 1) + 1;
    abort = (stop_at > 0) ? stop_at : rst_at;
    endc  = (abort > 0) ? abort : D;
    interval = CW'(iv); count = CW'(cnt); group_en = en;
    start = 1'b1; stop = noisy;
    @(posedge clk); @(negedge clk);
    start = 1'b0; stop = 1'b0;
    cur = m_lfsr; prev = cur;
    for (int c = 1; c <= endc + 1; c++) begin
      for (int j = 0; j < G; j++) expm[j] = '0;
      if (c <= endc && c % (I + 1) == 0 && (cnt == 0 || c / (I + 1) <= cnt)) begin
        g = pick(m_ptr, en);
        m_ptr = g;
        expm[g] = mk(prev);
      end
      lim = (abort > 0 && abort < c) ? abort : c;
      inj = (lim - 1) / (I + 1);
      if (cnt > 0 && inj > cnt) inj = cnt;
      if (rst_at > 0 && c > rst_at) inj = 0;
      chk("busy", 32'(busy), 32'(c <= endc));
      chk("done", 32'(done), 32'(abort == 0 && c == D));
      chk("injected", 32'(injected), 32'(inj));
      for (int j = 0; j < G; j++) chk($sformatf("upset%0d_c%0d", j, c), upset[j], expm[j]);
      if (noisy && c <= endc) begin
        interval = CW'($urandom_range(0, 7));
        count    = CW'($urandom_range(0, 7));
        start    = ($urandom_range(0, 2) == 0);
      end else start = 1'b0;
      stop = (stop_at > 0 && c == stop_at);
      rst  = (rst_at > 0 && c == rst_at);
      if (c <= endc) begin prev = cur; cur = lshift(cur); end
      @(posedge clk); @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
    if (rst_at > 0) begin m_lfsr = SEED; m_ptr = 0; end
    else m_lfsr = cur;
  endtask

  initial begin
    int iv, cnt, D, sa;
    logic [G-1:0] en;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_injected", 32'(injected), 32'h0);
    for (int j = 0; j < G; j++) chk("rst_upset", upset[j], 32'h0);

    campaign(3, 2, 4'b0001, 0, 0, 1'b0);
    campaign(1, 4, 4'b0101, 0, 0, 1'b0);
    campaign(5, 0, 4'b1111, 2, 0, 1'b0);
    campaign(0, 3, 4'b1010, 0, 0, 1'b1);

    // start with no enabled group is ignored
    group_en = '0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      chk("noen_busy", 32'(busy), 32'h0);
      @(posedge clk); @(negedge clk);
    end

    for (int n = 0; n < 10; n++) begin
      iv  = $urandom_range(0, 4);
      cnt = $urandom_range(1, 4);
      en  = G'($urandom_range(1, 15));
      D   = cnt * (((iv == 0) ? 1 : iv) + 1) + 1;
      sa  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, D - 1) : 0;
      campaign(iv, cnt, en, sa, 0, 1'($urandom_range(0, 1)));
    end
    campaign(3, 0, 4'b0110, 13, 0, 1'b1);

    // reset lands in the first INJECT cycle (I=2 -> c=3)
    campaign(2, 3, 4'b0011, 0, 3, 1'b1);
    campaign(2, 2, 4'b0100, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
